// File: rtl/level_detect_pkg.sv
// Shared types for the hysteresis level detector.
package level_detect_pkg;

  // Debounced classifier states: settled levels plus the two confirming states.
  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } state_t;

endpackage

// File: rtl/level_detect_sat_counter.sv
// Saturating up-counter with synchronous clear, increment and add.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         add,
  input  logic [W-1:0] add_val,
  output logic [W-1:0] q
);

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  logic [W-1:0] step;

  assign step = inc ? W'(1) : add_val;

  // Clear wins over any accumulate request; otherwise accumulate with saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc || add) begin
      q <= sat_add(q, step);
    end
  end

endmodule

// File: rtl/level_detect.sv
// Hysteresis + debounce level detector with rise/fall pulses and HIGH run length.
module level_detect
  import level_detect_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] th_hi,
  input  logic [WIDTH-1:0] th_lo,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] len,
  output logic             len_valid
);

  localparam int            DW       = $clog2(DEBOUNCE + 1);
  // dbc value at which one more qualifying sample confirms the transition.
  localparam logic [DW-1:0] DBC_LAST = DW'(DEBOUNCE - 1);

  state_t           state, state_nxt;
  logic             above, below;
  logic             run_clr, run_inc, run_add;
  logic [CNT_W-1:0] run_add_val, run_q;
  logic             dbc_clr, dbc_inc;
  logic [DW-1:0]    dbc_q;
  logic             rise_nxt, fall_nxt;

  assign above       = in > th_hi;
  assign below       = in < th_lo;
  // Aborted fall: the below-samples seen so far plus the current one count as HIGH.
  assign run_add_val = CNT_W'(dbc_q) + CNT_W'(1);

  sat_counter #(.W(CNT_W)) u_run (
    .clk     (clk),
    .rst     (rst),
    .clr     (run_clr),
    .inc     (run_inc),
    .add     (run_add),
    .add_val (run_add_val),
    .q       (run_q)
  );

  sat_counter #(.W(DW)) u_dbc (
    .clk     (clk),
    .rst     (rst),
    .clr     (dbc_clr),
    .inc     (dbc_inc),
    .add     (1'b0),
    .add_val ('0),
    .q       (dbc_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, counter controls and confirm strobes; idle when no sample is offered.
  always_comb begin
    state_nxt = state;
    run_clr   = 1'b0;
    run_inc   = 1'b0;
    run_add   = 1'b0;
    dbc_clr   = 1'b0;
    dbc_inc   = 1'b0;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (in_valid) begin
      unique case (state)
        LOW: begin
          if (above) begin
            run_inc = 1'b1;
            if (DEBOUNCE == 1) begin
              state_nxt = HIGH;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = RISING;
              dbc_inc   = 1'b1;
            end
          end
        end
        RISING: begin
          if (above) begin
            run_inc = 1'b1;
            if (dbc_q == DBC_LAST) begin
              state_nxt = HIGH;
              rise_nxt  = 1'b1;
              dbc_clr   = 1'b1;
            end else begin
              dbc_inc = 1'b1;
            end
          end else begin
            state_nxt = LOW;
            dbc_clr   = 1'b1;
            run_clr   = 1'b1;
          end
        end
        HIGH: begin
          if (below) begin
            if (DEBOUNCE == 1) begin
              state_nxt = LOW;
              fall_nxt  = 1'b1;
              run_clr   = 1'b1;
            end else begin
              state_nxt = FALLING;
              dbc_inc   = 1'b1;
            end
          end else begin
            run_inc = 1'b1;
          end
        end
        FALLING: begin
          if (below) begin
            if (dbc_q == DBC_LAST) begin
              state_nxt = LOW;
              fall_nxt  = 1'b1;
              run_clr   = 1'b1;
              dbc_clr   = 1'b1;
            end else begin
              dbc_inc = 1'b1;
            end
          end else begin
            state_nxt = HIGH;
            run_add   = 1'b1;
            dbc_clr   = 1'b1;
          end
        end
        default: state_nxt = LOW;
      endcase
    end
  end

  // Output registers: pulses last one cycle, level and len hold between confirms.
  always_ff @(posedge clk) begin
    if (rst) begin
      level     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      len_valid <= 1'b0;
      len       <= '0;
    end else begin
      rise      <= rise_nxt;
      fall      <= fall_nxt;
      len_valid <= fall_nxt;
      if (rise_nxt) begin
        level <= 1'b1;
      end else if (fall_nxt) begin
        level <= 1'b0;
      end
      if (fall_nxt) begin
        len <= run_q;
      end
    end
  end

endmodule

// File: tb/tb_level_detect.sv
// Self-checking bench for level_detect: three configurations share one stimulus stream.
module tb_level_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       in_valid;
  logic [7:0] th_hi, th_lo;

  logic        level0, rise0, fall0, lv0;
  logic [15:0] len0;
  logic        level1, rise1, fall1, lv1;
  logic [3:0]  len1;
  logic        level2, rise2, fall2, lv2;
  logic [15:0] len2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  level_detect #(.WIDTH(8), .CNT_W(16), .DEBOUNCE(3)) dut0 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .th_hi(th_hi), .th_lo(th_lo),
    .level(level0), .rise(rise0), .fall(fall0), .len(len0), .len_valid(lv0));

  level_detect #(.WIDTH(8), .CNT_W(4), .DEBOUNCE(3)) dut1 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .th_hi(th_hi), .th_lo(th_lo),
    .level(level1), .rise(rise1), .fall(fall1), .len(len1), .len_valid(lv1));

  level_detect #(.WIDTH(8), .CNT_W(16), .DEBOUNCE(1)) dut2 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .th_hi(th_hi), .th_lo(th_lo),
    .level(level2), .rise(rise2), .fall(fall2), .len(len2), .len_valid(lv2));

  // Reference model: count consecutive qualifying samples and total HIGH samples.
  int dbn[3]  = '{3, 3, 1};
  int lmax[3] = '{65535, 15, 65535};
  int m_lvl[3], m_streak[3], m_hi[3];
  int e_rise[3], e_fall[3], e_lv[3], e_len[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_lvl[k] = 0; m_streak[k] = 0; m_hi[k] = 0;
      e_rise[k] = 0; e_fall[k] = 0; e_lv[k] = 0; e_len[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_lvl[k] = 0; m_streak[k] = 0; m_hi[k] = 0;
        e_rise[k] = 0; e_fall[k] = 0; e_lv[k] = 0; e_len[k] = 0;
      end else begin
        e_rise[k] = 0; e_fall[k] = 0; e_lv[k] = 0;
        if (in_valid) begin
          if (m_lvl[k] == 0) begin
            if (din > th_hi) m_streak[k]++;
            else m_streak[k] = 0;
            if (m_streak[k] == dbn[k]) begin
              m_lvl[k] = 1; e_rise[k] = 1; m_hi[k] = dbn[k]; m_streak[k] = 0;
            end
          end else begin
            if (din < th_lo) m_streak[k]++;
            else begin
              m_hi[k] += m_streak[k] + 1;
              m_streak[k] = 0;
            end
            if (m_streak[k] == dbn[k]) begin
              m_lvl[k] = 0; e_fall[k] = 1; e_lv[k] = 1;
              e_len[k] = (m_hi[k] > lmax[k]) ? lmax[k] : m_hi[k];
              m_hi[k] = 0; m_streak[k] = 0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare every output of every instance against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level0", {31'd0, level0}, m_lvl[0]);
      chk("rise0",  {31'd0, rise0},  e_rise[0]);
      chk("fall0",  {31'd0, fall0},  e_fall[0]);
      chk("lv0",    {31'd0, lv0},    e_lv[0]);
      chk("len0",   {16'd0, len0},   e_len[0]);
      chk("level1", {31'd0, level1}, m_lvl[1]);
      chk("rise1",  {31'd0, rise1},  e_rise[1]);
      chk("fall1",  {31'd0, fall1},  e_fall[1]);
      chk("lv1",    {31'd0, lv1},    e_lv[1]);
      chk("len1",   {28'd0, len1},   e_len[1]);
      chk("level2", {31'd0, level2}, m_lvl[2]);
      chk("rise2",  {31'd0, rise2},  e_rise[2]);
      chk("fall2",  {31'd0, fall2},  e_fall[2]);
      chk("lv2",    {31'd0, lv2},    e_lv[2]);
      chk("len2",   {16'd0, len2},   e_len[2]);
    end
  end

  // Apply one sample at the falling edge; return just after the capturing rising edge.
  task automatic step(input int v, input bit vld, input bit r);
    @(negedge clk);
    din      = 8'(v);
    in_valid = vld;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cat;
    int v;
    rst = 1'b1; din = 8'd0; in_valid = 1'b1; th_hi = 8'd100; th_lo = 8'd50;

    // Reset held with an above-threshold sample.
    for (int i = 0; i < 4; i++) begin
      step(128, 1, 1);
      chk_en = 1;
      chk("rst_level", {31'd0, level0}, 0);
      chk("rst_pulses", {29'd0, rise0, fall0, lv0}, 0);
      chk("rst_len", {16'd0, len0}, 0);
    end

    // Clean rise, long HIGH run, clean fall.
    step(0, 1, 0); step(128, 1, 0); step(124, 1, 0);
    chk("pre_rise", {31'd0, rise0}, 0);
    step(127, 1, 0);
    chk("rise_pulse", {31'd0, rise0}, 1);
    chk("rise_level", {31'd0, level0}, 1);
    chk("rise_d1", {31'd0, level2}, 1);
    for (int i = 0; i < 20; i++) step(124, 1, 0);
    step(0, 1, 0); step(0, 1, 0);
    chk("fall_wait", {31'd0, level0}, 1);
    step(0, 1, 0);
    chk("fall_pulse", {30'd0, fall0, lv0}, 2'b11);
    chk("fall_len23", {16'd0, len0}, 23);
    chk("model_len23", e_len[0], 23);
    chk("sat_len15", {28'd0, len1}, 15);
    chk("d1_len23", {16'd0, len2}, 23);
    step(0, 1, 0);
    chk("len_hold", {16'd0, len0}, 23);
    chk("fall_clear", {31'd0, fall0}, 0);

    // Glitch aborts the rise, then a clean rise.
    step(0, 1, 0); step(128, 1, 0); step(124, 1, 0); step(0, 1, 0); step(128, 1, 0);
    chk("glitch_level", {31'd0, level0}, 0);
    step(124, 1, 0); step(127, 1, 0);
    chk("glitch_rise", {31'd0, rise0}, 1);

    // Aborted fall counts its samples as HIGH.
    step(0, 1, 0); step(0, 1, 0); step(75, 1, 0);
    chk("abort_level", {31'd0, level0}, 1);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    chk("abort_len6", {16'd0, len0}, 6);
    chk("model_len6", e_len[0], 6);

    // in_valid gaps delay the rise; gap samples would otherwise abort it.
    step(128, 1, 0); step(0, 0, 0); step(124, 1, 0); step(0, 0, 0);
    chk("gap_norise", {31'd0, level0}, 0);
    step(127, 1, 0);
    chk("gap_rise", {31'd0, rise0}, 1);
    step(0, 0, 0);
    chk("gap_pulse_drop", {31'd0, rise0}, 0);
    for (int i = 0; i < 17; i++) step(124, 1, 0);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    chk("run20_len", {16'd0, len0}, 20);
    chk("run20_sat", {28'd0, len1}, 15);

    // Reset in the middle of a HIGH run emits nothing.
    step(128, 1, 0); step(124, 1, 0); step(127, 1, 0);
    step(124, 1, 1);
    chk("midrst_level", {31'd0, level0}, 0);
    chk("midrst_fall", {31'd0, fall0}, 0);
    chk("midrst_len", {16'd0, len0}, 0);
    step(0, 1, 0);

    // Randomized sticky stimulus with moving thresholds and occasional reset.
    cat = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        th_lo = 8'($urandom_range(30, 120));
        th_hi = 8'($urandom_range(90, 220));
      end
      if ($urandom_range(0, 99) < 15) cat = $urandom_range(0, 2);
      case (cat)
        0:       v = $urandom_range(0, 40);
        1:       v = $urandom_range(41, 200);
        default: v = $urandom_range(201, 255);
      endcase
      step(v, ($urandom_range(0, 9) < 8), ($urandom_range(0, 299) == 0));
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
